cache_bus_arbiter: RTL and testbench
====================================

Name: cache_bus_arbiter

Overview:
- Shares one Wishbone B4 (classic, pipelined-off) memory port between N_MASTERS cache controllers (instruction cache, data cache, further cores).
- Grants are round-robin and last for a whole bus cycle. A grant is held for as long as the owner keeps CYC asserted, so cache line fills and write-backs are never split.
- Every acknowledged write is broadcast on the snoop bus so that peer caches invalidate matching lines. This is the coherence source for the snoopy protocol.
- A watchdog terminates stalled transfers with ERR.

Parameters:
- N_MASTERS, 2, number of requesting caches (2..8).
- ADDR_WIDTH, 32, address bits.
- DATA_WIDTH, 32, data bits. SEL width is DATA_WIDTH/8.
- TIMEOUT, 255, maximum cycles a strobe may wait for slave ACK/ERR before the arbiter forces ERR.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- m_cyc  in  N_MASTERS  per-master CYC.
- m_stb  in  N_MASTERS  per-master STB.
- m_we  in  N_MASTERS  per-master WE.
- m_adr  in  N_MASTERS*ADDR_WIDTH  per-master address, master i in slice i.
- m_dat_w  in  N_MASTERS*DATA_WIDTH  per-master write data.
- m_sel  in  N_MASTERS*DATA_WIDTH/8  per-master byte select.
- m_ack  out  N_MASTERS  per-master ACK.
- m_err  out  N_MASTERS  per-master ERR.
- m_dat_r  out  DATA_WIDTH  read data, shared by all masters and valid only with m_ack.
- s_cyc  out  1  slave CYC.
- s_stb  out  1  slave STB.
- s_we  out  1  slave WE.
- s_adr  out  ADDR_WIDTH  slave address.
- s_dat_w  out  DATA_WIDTH  slave write data.
- s_sel  out  DATA_WIDTH/8  slave byte select.
- s_ack  in  1  slave ACK.
- s_err  in  1  slave ERR.
- s_dat_r  in  DATA_WIDTH  slave read data.
- snoop_valid  out  1  one-cycle pulse: a write has completed.
- snoop_adr  out  ADDR_WIDTH  address of the completed write.
- snoop_src  out  $clog2(N_MASTERS)  index of the writing master.
- owner  out  $clog2(N_MASTERS)  current or last grant, for debug.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; owner=0; round-robin pointer=0; watchdog=0.
  - All outputs low: s_cyc, s_stb, m_ack, m_err, snoop_valid.
  - Bus outputs s_adr, s_dat_w, s_sel, s_we = 0.
- FSM states are IDLE, BUSY, ABORT.
- IDLE:
  - If any m_cyc is high, grant the first requester at or after pointer, in modulo-N order.
  - owner <= winner; go to BUSY on the next edge.
  - Grant latency is 1 cycle from m_cyc to s_cyc.
  - No request: stay in IDLE.
- BUSY:
  - s_cyc, s_stb, s_we, s_adr, s_dat_w and s_sel are combinational muxes of the owner's signals, with s_cyc = m_cyc[owner].
  - m_ack[owner] = s_ack and m_err[owner] = s_err, combinational. All other masters read 0.
  - m_dat_r = s_dat_r.
  - Watchdog counts cycles in which s_stb=1 and neither s_ack nor s_err is high. It clears on ACK/ERR or when STB is low.
  - Watchdog reaching TIMEOUT: go to ABORT.
  - m_cyc[owner] falls: pointer <= owner+1 (wraps to 0 after N_MASTERS-1); go to IDLE.
  - There is one mandatory idle cycle between owners, so back-to-back cycles by the same master also incur 1 dead cycle.
- ABORT:
  - Lasts one cycle.
  - s_cyc=0 and s_stb=0.
  - m_err[owner]=1 for exactly this cycle.
  - Watchdog cleared; pointer <= owner+1; go to IDLE.
  - A late s_ack arriving in ABORT or IDLE is ignored and never routed.
- Snoop:
  - On a cycle with s_ack=1 and s_we=1 in BUSY, register snoop_adr=s_adr and snoop_src=owner.
  - snoop_valid=1 on the following cycle only.
  - Reads and ERR-terminated writes produce no snoop.
  - In a burst, each acked write beat produces its own pulse, so consecutive beats give consecutive pulses.
- Simultaneous events:
  - s_ack, s_err: ACK and ERR both high in the same cycle are both passed through. No snoop is generated.
  - m_cyc drop and s_ack: m_cyc[owner] dropping in the same cycle as s_ack still completes the beat (ACK and snoop issued), then returns to IDLE.
- Requesters that are not the owner see no ACK/ERR and may hold CYC/STB indefinitely.
- A master dropping CYC while waiting simply withdraws its request.
- Reset asserted mid-transfer: the bus is released immediately, with no ERR and no snoop.

Test Plan:
- Single read: m_cyc[0]=m_stb[0]=1, m_adr[0]=0x100, slave ACKs 2 cycles after s_stb with s_dat_r=0xDEADBEEF → s_cyc rises 1 cycle after m_cyc; m_ack[0] pulses with m_dat_r=0xDEADBEEF; snoop_valid stays 0.
- Round-robin fairness: masters 0 and 1 both request continuously with 1-beat cycles → grants alternate 0,1,0,1. Each grant is separated by exactly 1 IDLE cycle.
- Burst hold: master 1 holds CYC for 4 beats of writes to 0x200..0x20C while master 0 requests → master 0 gets no ACK until master 1 drops CYC. snoop_valid pulses 4 times with snoop_adr 0x200, 0x204, 0x208, 0x20C and snoop_src=1.
- Timeout: TIMEOUT=8, slave never ACKs → after 8 stalled cycles, m_err[owner] pulses for 1 cycle and s_cyc drops. Next requester granted; a late s_ack is not forwarded.
- Error write: slave returns s_err on a write to 0x300 → m_err pulses; no snoop_valid.
- Reset mid-burst: drive rst=0 during a BUSY write → all outputs 0 asynchronously; after rst=1, the first grant goes to master 0.

Source files
------------

// File: rtl/cache_bus_arbiter.sv
// -----------------------------------------------------------------------------
// cache_bus_arbiter
//
// Shares one Wishbone B4 classic memory port between N_MASTERS cache
// controllers. Grants are round-robin and last for a whole bus cycle: the
// owner keeps the port for as long as it holds CYC, so line fills and
// write-backs are never split. A single dead cycle separates consecutive
// owners, including back-to-back cycles by the same master.
//
// Every acknowledged write is published on the snoop outputs one cycle later
// so that peer caches can invalidate matching lines. A watchdog ends a strobe
// that has waited too long for the slave by forcing ERR to the owner.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   m_cyc_i/m_stb_i/m_we_i/m_adr_i/m_dat_w_i/m_sel_i
//                      per-master Wishbone requests, master i in slice i
//   m_ack_o, m_err_o   per-master terminations (only the owner ever sees them)
//   m_dat_r_o          shared read data, valid with m_ack_o
//   s_*                Wishbone master port towards the memory slave
//   snoop_valid_o      one-cycle pulse per completed write
//   snoop_adr_o        address of that write
//   snoop_src_o        index of the master that wrote
//   owner_o            current or most recent grant
// -----------------------------------------------------------------------------
module cache_bus_arbiter #(
  parameter int unsigned N_MASTERS  = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255,
  localparam int unsigned SelW      = DATA_WIDTH / 8,
  localparam int unsigned IdxW      = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1,
  localparam int unsigned WdogW     = $clog2(TIMEOUT + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  // Cache-side requests
  input  logic [N_MASTERS-1:0]             m_cyc_i,
  input  logic [N_MASTERS-1:0]             m_stb_i,
  input  logic [N_MASTERS-1:0]             m_we_i,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0]  m_adr_i,
  input  logic [N_MASTERS*DATA_WIDTH-1:0]  m_dat_w_i,
  input  logic [N_MASTERS*SelW-1:0]        m_sel_i,
  output logic [N_MASTERS-1:0]             m_ack_o,
  output logic [N_MASTERS-1:0]             m_err_o,
  output logic [DATA_WIDTH-1:0]            m_dat_r_o,
  // Memory-side port
  output logic                             s_cyc_o,
  output logic                             s_stb_o,
  output logic                             s_we_o,
  output logic [ADDR_WIDTH-1:0]            s_adr_o,
  output logic [DATA_WIDTH-1:0]            s_dat_w_o,
  output logic [SelW-1:0]                  s_sel_o,
  input  logic                             s_ack_i,
  input  logic                             s_err_i,
  input  logic [DATA_WIDTH-1:0]            s_dat_r_i,
  // Coherence and debug
  output logic                             snoop_valid_o,
  output logic [ADDR_WIDTH-1:0]            snoop_adr_o,
  output logic [IdxW-1:0]                  snoop_src_o,
  output logic [IdxW-1:0]                  owner_o
);

  typedef enum logic [1:0] {StIdle, StBusy, StAbort} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       owner_q, owner_d;
  logic [IdxW-1:0]       ptr_q, ptr_d;
  logic [WdogW-1:0]      wdog_q, wdog_d;
  logic                  snoop_valid_q, snoop_valid_d;
  logic [ADDR_WIDTH-1:0] snoop_adr_q, snoop_adr_d;
  logic [IdxW-1:0]       snoop_src_q, snoop_src_d;

  // Owner's request signals, selected by the registered grant.
  logic                  own_cyc, own_stb, own_we;
  logic [ADDR_WIDTH-1:0] own_adr;
  logic [DATA_WIDTH-1:0] own_dat_w;
  logic [SelW-1:0]       own_sel;

  always_comb begin
    own_cyc   = 1'b0;
    own_stb   = 1'b0;
    own_we    = 1'b0;
    own_adr   = '0;
    own_dat_w = '0;
    own_sel   = '0;
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      if (owner_q == IdxW'(i)) begin
        own_cyc   = m_cyc_i[i];
        own_stb   = m_stb_i[i];
        own_we    = m_we_i[i];
        own_adr   = m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        own_dat_w = m_dat_w_i[i*DATA_WIDTH +: DATA_WIDTH];
        own_sel   = m_sel_i[i*SelW +: SelW];
      end
    end
  end

  // Round-robin pick: first requester at or above the pointer, otherwise the
  // lowest-numbered requester (wrap-around part of the modulo-N search).
  logic            found;
  logic [IdxW-1:0] winner;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      if (!found && m_cyc_i[i] && (IdxW'(i) >= ptr_q)) begin
        found  = 1'b1;
        winner = IdxW'(i);
      end
    end
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      if (!found && m_cyc_i[i]) begin
        found  = 1'b1;
        winner = IdxW'(i);
      end
    end
  end

  logic [IdxW-1:0] owner_inc;
  assign owner_inc = (owner_q == IdxW'(N_MASTERS - 1)) ? '0 : owner_q + 1'b1;

  logic stalled;
  assign stalled = own_stb && !s_ack_i && !s_err_i;

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    ptr_d         = ptr_q;
    wdog_d        = '0;
    snoop_valid_d = 1'b0;
    snoop_adr_d   = snoop_adr_q;
    snoop_src_d   = snoop_src_q;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          owner_d = winner;
          state_d = StBusy;
        end
      end

      StBusy: begin
        // A write beat completes even when CYC drops in the same cycle; an
        // ACK accompanied by ERR is not a clean completion and is not snooped.
        if (s_ack_i && !s_err_i && own_we) begin
          snoop_valid_d = 1'b1;
          snoop_adr_d   = own_adr;
          snoop_src_d   = owner_q;
        end

        if (!own_cyc) begin
          ptr_d   = owner_inc;
          state_d = StIdle;
        end else if (stalled) begin
          // Leave on the cycle that would make the count reach TIMEOUT.
          if (wdog_q == WdogW'(TIMEOUT - 1)) begin
            state_d = StAbort;
          end else begin
            wdog_d = wdog_q + 1'b1;
          end
        end
      end

      StAbort: begin
        ptr_d   = owner_inc;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      owner_q       <= '0;
      ptr_q         <= '0;
      wdog_q        <= '0;
      snoop_valid_q <= 1'b0;
      snoop_adr_q   <= '0;
      snoop_src_q   <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      ptr_q         <= ptr_d;
      wdog_q        <= wdog_d;
      snoop_valid_q <= snoop_valid_d;
      snoop_adr_q   <= snoop_adr_d;
      snoop_src_q   <= snoop_src_d;
    end
  end

  // Outputs. The slave port is only driven while a grant is active, so
  // the bus is released the moment the state leaves BUSY (including reset).
  logic busy, abort;
  assign busy  = (state_q == StBusy);
  assign abort = (state_q == StAbort);

  always_comb begin
    s_cyc_o   = busy & own_cyc;
    s_stb_o   = busy & own_stb;
    s_we_o    = busy & own_we;
    s_adr_o   = busy ? own_adr   : '0;
    s_dat_w_o = busy ? own_dat_w : '0;
    s_sel_o   = busy ? own_sel   : '0;
    m_dat_r_o = busy ? s_dat_r_i : '0;
    m_ack_o   = '0;
    m_err_o   = '0;
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      if (owner_q == IdxW'(i)) begin
        // Late terminations in ABORT/IDLE are never routed.
        m_ack_o[i] = busy & s_ack_i;
        m_err_o[i] = (busy & s_err_i) | abort;
      end
    end
  end

  assign snoop_valid_o = snoop_valid_q;
  assign snoop_adr_o   = snoop_adr_q;
  assign snoop_src_o   = snoop_src_q;
  assign owner_o       = owner_q;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench for cache_bus_arbiter with two masters and a short watchdog.
// Inputs change on the falling clock edge; outputs are sampled 1 ns later.
module tb_cache_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  m_cyc, m_stb, m_we;
  logic [63:0] m_adr, m_dat_w;
  logic [7:0]  m_sel;
  logic [1:0]  m_ack, m_err;
  logic [31:0] m_dat_r;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat_w;
  logic [3:0]  s_sel;
  logic        s_ack, s_err;
  logic [31:0] s_dat_r;
  logic        snoop_valid;
  logic [31:0] snoop_adr;
  logic [0:0]  snoop_src, owner;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_bus_arbiter #(
    .N_MASTERS (2),
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT   (8)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .m_cyc_i      (m_cyc),
    .m_stb_i      (m_stb),
    .m_we_i       (m_we),
    .m_adr_i      (m_adr),
    .m_dat_w_i    (m_dat_w),
    .m_sel_i      (m_sel),
    .m_ack_o      (m_ack),
    .m_err_o      (m_err),
    .m_dat_r_o    (m_dat_r),
    .s_cyc_o      (s_cyc),
    .s_stb_o      (s_stb),
    .s_we_o       (s_we),
    .s_adr_o      (s_adr),
    .s_dat_w_o    (s_dat_w),
    .s_sel_o      (s_sel),
    .s_ack_i      (s_ack),
    .s_err_i      (s_err),
    .s_dat_r_i    (s_dat_r),
    .snoop_valid_o(snoop_valid),
    .snoop_adr_o  (snoop_adr),
    .snoop_src_o  (snoop_src),
    .owner_o      (owner)
  );

  task automatic nxt;
    @(negedge clk);
  endtask

  task automatic test_reset;
    // Requests and a stray ACK present while reset is held.
    m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b11;
    m_adr = {32'h44, 32'h40}; m_dat_w = {32'h1111, 32'h2222}; m_sel = 8'hFF;
    s_ack = 1'b1; s_err = 1'b0; s_dat_r = 32'h0;
    nxt; nxt;
    #1;
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL reset_s_cyc: got %b want 0", s_cyc); end
    checks++; if (s_adr !== 32'h0) begin errors++; $display("FAIL reset_s_adr: got %h want 0", s_adr); end
    checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL reset_m_ack: got %b want 00", m_ack); end
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL reset_owner: got %b want 0", owner); end
    checks++; if (snoop_valid !== 1'b0) begin errors++; $display("FAIL reset_snoop: got %b want 0", snoop_valid); end
    m_cyc = 2'b00; m_stb = 2'b00; m_we = 2'b00; s_ack = 1'b0;
    rst_n = 1'b1;
    nxt;
  endtask

  task automatic test_single_read;
    m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b00; m_adr[31:0] = 32'h100; m_sel = 8'h0F;
    #1;
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL read_latency: got %b want 0", s_cyc); end
    nxt; #1;
    checks++; if (s_cyc !== 1'b1) begin errors++; $display("FAIL read_s_cyc: got %b want 1", s_cyc); end
    checks++; if (s_adr !== 32'h100) begin errors++; $display("FAIL read_s_adr: got %h want 100", s_adr); end
    checks++; if (s_sel !== 4'hF) begin errors++; $display("FAIL read_s_sel: got %h want f", s_sel); end
    nxt; nxt;
    s_ack = 1'b1; s_dat_r = 32'hDEADBEEF;
    #1;
    checks++; if (m_ack !== 2'b01) begin errors++; $display("FAIL read_m_ack: got %b want 01", m_ack); end
    checks++; if (m_dat_r !== 32'hDEADBEEF) begin errors++; $display("FAIL read_dat: got %h want deadbeef", m_dat_r); end
    nxt;
    s_ack = 1'b0; m_cyc = 2'b00; m_stb = 2'b00;
    #1;
    checks++; if (snoop_valid !== 1'b0) begin errors++; $display("FAIL read_no_snoop: got %b want 0", snoop_valid); end
    nxt;
  endtask

  task automatic test_round_robin;
    logic [0:0] exp;
    logic [1:0] exp_ack;
    logic [31:0] exp_adr;
    exp = 1'b1;  // pointer sits after master 0 following the single read
    m_adr = {32'h14, 32'h10}; m_we = 2'b00;
    m_cyc = 2'b11; m_stb = 2'b11;
    for (int g = 0; g < 4; g++) begin
      exp_ack = (exp == 1'b1) ? 2'b10 : 2'b01;
      exp_adr = (exp == 1'b1) ? 32'h14 : 32'h10;
      #1;
      checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL rr_dead_cycle[%0d]: got %b want 0", g, s_cyc); end
      nxt; #1;
      checks++; if (owner !== exp) begin errors++; $display("FAIL rr_owner[%0d]: got %b want %b", g, owner, exp); end
      checks++; if (s_adr !== exp_adr) begin errors++; $display("FAIL rr_adr[%0d]: got %h want %h", g, s_adr, exp_adr); end
      s_ack = 1'b1; s_dat_r = 32'h1000 + g;
      #1;
      checks++; if (m_ack !== exp_ack) begin errors++; $display("FAIL rr_ack[%0d]: got %b want %b", g, m_ack, exp_ack); end
      nxt;
      s_ack = 1'b0; m_cyc[exp] = 1'b0; m_stb[exp] = 1'b0;
      nxt;
      if (g < 3) begin m_cyc = 2'b11; m_stb = 2'b11; end
      exp = ~exp;
    end
  endtask

  task automatic test_burst_hold;
    m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b10;
    m_adr = {32'h200, 32'h40}; m_dat_w = {32'hB000, 32'h0};
    nxt; #1;
    checks++; if (owner !== 1'b1) begin errors++; $display("FAIL burst_owner: got %b want 1", owner); end
    checks++; if (s_we !== 1'b1) begin errors++; $display("FAIL burst_we: got %b want 1", s_we); end
    for (int b = 0; b < 4; b++) begin
      if (b > 0) begin
        checks++; if (snoop_valid !== 1'b1) begin errors++; $display("FAIL burst_snoop_valid[%0d]: got %b want 1", b - 1, snoop_valid); end
        checks++; if (snoop_adr !== 32'h200 + 4 * (b - 1)) begin errors++; $display("FAIL burst_snoop_adr[%0d]: got %h want %h", b - 1, snoop_adr, 32'h200 + 4 * (b - 1)); end
        checks++; if (snoop_src !== 1'b1) begin errors++; $display("FAIL burst_snoop_src[%0d]: got %b want 1", b - 1, snoop_src); end
      end
      m_adr[63:32] = 32'h200 + 4 * b; m_dat_w[63:32] = 32'hB000 + b;
      s_ack = 1'b1;
      #1;
      checks++; if (m_ack !== 2'b10) begin errors++; $display("FAIL burst_ack[%0d]: got %b want 10", b, m_ack); end
      checks++; if (s_adr !== 32'h200 + 4 * b) begin errors++; $display("FAIL burst_adr[%0d]: got %h want %h", b, s_adr, 32'h200 + 4 * b); end
      nxt;
    end
    s_ack = 1'b0; m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b00;
    #1;
    checks++; if (snoop_valid !== 1'b1) begin errors++; $display("FAIL burst_snoop_valid[3]: got %b want 1", snoop_valid); end
    checks++; if (snoop_adr !== 32'h20C) begin errors++; $display("FAIL burst_snoop_adr[3]: got %h want 20c", snoop_adr); end
    checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL burst_drop_ack: got %b want 00", m_ack); end
    nxt; #1;
    checks++; if (snoop_valid !== 1'b0) begin errors++; $display("FAIL burst_snoop_end: got %b want 0", snoop_valid); end
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL burst_dead_cycle: got %b want 0", s_cyc); end
    nxt; #1;
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL burst_next_owner: got %b want 0", owner); end
    checks++; if (s_adr !== 32'h40) begin errors++; $display("FAIL burst_next_adr: got %h want 40", s_adr); end
    s_ack = 1'b1; s_dat_r = 32'h5;
    #1;
    checks++; if (m_ack !== 2'b01) begin errors++; $display("FAIL burst_next_ack: got %b want 01", m_ack); end
    nxt;
    s_ack = 1'b0; m_cyc = 2'b00; m_stb = 2'b00;
    #1;
    checks++; if (snoop_valid !== 1'b0) begin errors++; $display("FAIL burst_read_no_snoop: got %b want 0", snoop_valid); end
    nxt;
  endtask

  task automatic test_timeout;
    m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b00;
    m_adr = {32'h600, 32'h500};
    nxt; #1;
    checks++; if (owner !== 1'b1) begin errors++; $display("FAIL to_owner: got %b want 1", owner); end
    for (int k = 1; k <= 8; k++) begin
      #1;
      checks++; if (m_err !== 2'b00) begin errors++; $display("FAIL to_early_err[%0d]: got %b want 00", k, m_err); end
      nxt;
    end
    #1;
    checks++; if (m_err !== 2'b10) begin errors++; $display("FAIL to_err: got %b want 10", m_err); end
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL to_s_cyc: got %b want 0", s_cyc); end
    checks++; if (s_stb !== 1'b0) begin errors++; $display("FAIL to_s_stb: got %b want 0", s_stb); end
    s_ack = 1'b1;
    #1;
    checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL to_late_ack_abort: got %b want 00", m_ack); end
    nxt;
    m_cyc = 2'b01; m_stb = 2'b01;
    #1;
    checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL to_late_ack_idle: got %b want 00", m_ack); end
    checks++; if (m_err !== 2'b00) begin errors++; $display("FAIL to_err_one_cycle: got %b want 00", m_err); end
    nxt;
    s_ack = 1'b0;
    #1;
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL to_next_owner: got %b want 0", owner); end
    checks++; if (s_adr !== 32'h500) begin errors++; $display("FAIL to_next_adr: got %h want 500", s_adr); end
    s_ack = 1'b1;
    #1;
    checks++; if (m_ack !== 2'b01) begin errors++; $display("FAIL to_next_ack: got %b want 01", m_ack); end
    nxt;
    s_ack = 1'b0; m_cyc = 2'b00; m_stb = 2'b00;
    nxt;
  endtask

  task automatic test_error_write;
    m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01; m_adr[31:0] = 32'h300;
    nxt; #1;
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL errw_owner: got %b want 0", owner); end
    s_err = 1'b1;
    #1;
    checks++; if (m_err !== 2'b01) begin errors++; $display("FAIL errw_err: got %b want 01", m_err); end
    checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL errw_ack: got %b want 00", m_ack); end
    nxt;
    s_err = 1'b0; m_cyc = 2'b00; m_stb = 2'b00; m_we = 2'b00;
    #1;
    checks++; if (snoop_valid !== 1'b0) begin errors++; $display("FAIL errw_no_snoop: got %b want 0", snoop_valid); end
    nxt;
  endtask

  task automatic test_reset_mid_burst;
    m_cyc = 2'b10; m_stb = 2'b10; m_we = 2'b10; m_adr[63:32] = 32'h700;
    nxt; #1;
    checks++; if (owner !== 1'b1) begin errors++; $display("FAIL rstmid_owner: got %b want 1", owner); end
    s_ack = 1'b1;
    #1;
    checks++; if (m_ack !== 2'b10) begin errors++; $display("FAIL rstmid_ack: got %b want 10", m_ack); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL rstmid_s_cyc: got %b want 0", s_cyc); end
    checks++; if (s_adr !== 32'h0) begin errors++; $display("FAIL rstmid_s_adr: got %h want 0", s_adr); end
    checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL rstmid_m_ack: got %b want 00", m_ack); end
    checks++; if (m_err !== 2'b00) begin errors++; $display("FAIL rstmid_m_err: got %b want 00", m_err); end
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL rstmid_owner_clr: got %b want 0", owner); end
    s_ack = 1'b0; m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b00;
    nxt; #1;
    checks++; if (snoop_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_snoop: got %b want 0", snoop_valid); end
    rst_n = 1'b1;
    nxt; #1;
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL rstmid_first_grant: got %b want 0", owner); end
    checks++; if (s_cyc !== 1'b1) begin errors++; $display("FAIL rstmid_regrant_cyc: got %b want 1", s_cyc); end
    m_cyc = 2'b00; m_stb = 2'b00;
    nxt;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_burst_hold();
    test_timeout();
    test_error_write();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: bench still running at %0t, expected to have finished", $time);
    $fatal(1);
  end

endmodule
